shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier, the inverse companion to the team's restoring divider. It computes one partial product per clock over a start/busy/done handshake. Its output width matches the divider's dividend path, so a product can be fed straight back into the divider for round-trip checks. It sits beside the divider in the arithmetic test fixture on the same single clock domain.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled on the rising edge, honoured only when idle.
- A  in  WIDTH  multiplicand (unsigned).
- B  in  WIDTH  multiplier (unsigned).
- P  out  2*WIDTH  product register; holds the last completed result.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse when P has just been updated.

## Operation
- States: IDLE, RUN.
- IDLE, start=1 at an edge:
  - latch A into mcand;
  - load acc[2*WIDTH-1:0] = {WIDTH'b0, B};
  - load cnt = 0; set busy = 1; go to RUN.
- IDLE, start=0: no change; P holds.
- RUN, each edge, one iteration:
  - sum[WIDTH:0] = acc[2*WIDTH-1:WIDTH] + (acc[0] ? mcand : 0), computed at WIDTH+1 bits so the carry is kept;
  - acc <= {sum, acc[WIDTH-1:1]}, a logical right shift that takes in the carry;
  - cnt <= cnt + 1.
- Last iteration (cnt == WIDTH-1):
  - P <= final acc value; done <= 1; busy <= 0; go to IDLE.
- Arithmetic:
  - unsigned only; the result is exact for all operands, so no overflow is possible in 2*WIDTH bits;
  - cnt width is clog2(WIDTH) + 1; it does not wrap within an operation.
- Fixed latency: there is no early exit for zero or one operands.
- start while RUN is ignored, including on the edge where done rises. It is neither queued nor flagged.
- A and B may change freely after the accepting edge, because the operands are latched internally.
- rst_n low at any time, including mid-RUN:
  - immediately P = 0, done = 0, busy = 0, state = IDLE;
  - the in-flight operation is discarded;
  - the internal acc, mcand and cnt are cleared.
- Reset values: P = 0, busy = 0, done = 0.

## Timing
- Start is accepted at edge k.
- busy is high from edge k to edge k+WIDTH (WIDTH cycles).
- P updates and done pulses high at edge k+WIDTH; done is low again after edge k+WIDTH+1.
- The earliest next accepted start is edge k+WIDTH+1, so the minimum issue interval is WIDTH+1 cycles.
- P is stable from edge k+WIDTH until the next completion or reset. It does not change at start acceptance.
- Reset deassertion is not synchronised inside the block. rst_n must be released away from a clk edge, and start is only honoured from the first edge after release.

## Test plan
- WIDTH=4, A=13, B=11, start for 1 cycle -> busy high 4 cycles; at edge k+4 P=143 (0x8F), done=1 for exactly one cycle.
- WIDTH=4, A=15, B=15 -> P=225 (0xE1), which exercises the carry into the top bit. Then A=0, B=9 -> P=0 after the full 4-cycle latency, with done still pulsed.
- WIDTH=4: start A=6, B=7; at edge k+2 drive start=1 with A=3, B=3, and hold start=1 through edge k+4 -> P=42 at edge k+4 and the second request is ignored. Keep start=1 at edge k+5 -> accepted, P=9 at edge k+9.
- WIDTH=4: start A=9, B=5, then change A/B to 0 the cycle after acceptance -> P=45.
- WIDTH=4, P already 45: start A=12, B=12, pull rst_n low at edge k+2 -> P=0, busy=0, done=0 asynchronously with no done pulse. After release, A=2, B=3 -> P=6.
- WIDTH=8, A=255, B=255 -> P=65025 (0xFE01) at edge k+8. Random sweep of 1000 operand pairs, each checked against a reference A*B, including feeding P back to the divider (P / B = A, remainder 0 for B != 0).

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake bundle for the sequential shift-and-add multiplier.
// The master drives the request and operands; the slave returns product and status.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [2*WIDTH-1:0]   p_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output start_i,
        output a_i,
        output b_i,
        input  p_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  a_i,
        input  b_i,
        output p_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned multiplier that folds in one partial product per clock.
// The product appears WIDTH cycles after a start is accepted, with a one-cycle done pulse.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shift_add_multiplier_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q,   acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]   p_q,     p_d;
    logic                 done_q,  done_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   accShift;

    // The upper half accumulates; the carry out of the add becomes the new top bit on shift.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign accShift = {sum, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    mcand_d = bus.a_i;
                    acc_d   = {{WIDTH{1'b0}}, bus.b_i};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = accShift;
                cnt_d = cnt_q + CW'(1);
                // Starts seen here, including on the completing edge, are dropped.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    p_d     = accShift;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.p_o    = p_q;
    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = done_q;

endmodule
